traffic_light_monitor: RTL and testbench

- Passive observer on the six-lamp interface driven by the NS/EW traffic light controller. It is the receiving end of the lamp interface.
- Decodes the lamp vector into a phase and tracks phase order and per-phase dwell time against parameterised expectations.
- Counts completed signal cycles and raises error pulses plus a sticky error flag.
- Used in benches and on-chip alongside the controller; it never drives the lamps.

---
 rtl/traffic_pkg.sv | 46 ++++
 rtl/traffic_light_monitor_lamp_decoder.sv | 22 ++
 rtl/traffic_light_monitor.sv | 138 +++++++++++++
 tb/tb_traffic_light_monitor.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the NS/EW traffic light lamp interface:
// phase codes, legal lamp patterns, phase ordering and default dwell times.
package traffic_pkg;

  localparam int unsigned PHASE_W         = 3;
  localparam int unsigned LAMP_W          = 6;
  localparam int unsigned DWELL_W         = 8;
  localparam int unsigned G_TICKS_DEFAULT = 5;
  localparam int unsigned Y_TICKS_DEFAULT = 2;

  typedef enum logic [PHASE_W-1:0] {
    PH_SYNC = 3'd0,
    PH_NS_G = 3'd1,
    PH_NS_Y = 3'd2,
    PH_EW_G = 3'd3,
    PH_EW_Y = 3'd4
  } phase_e;

  // Lamp vector order is {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}.
  typedef struct packed {
    logic g;
    logic y;
    logic r;
  } lamp_grp_t;

  typedef struct packed {
    lamp_grp_t ns;
    lamp_grp_t ew;
  } lamps_t;

  localparam lamps_t LAMP_NS_G = 6'b100_001;
  localparam lamps_t LAMP_NS_Y = 6'b010_001;
  localparam lamps_t LAMP_EW_G = 6'b001_100;
  localparam lamps_t LAMP_EW_Y = 6'b001_010;

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      PH_NS_G: next_phase = PH_NS_Y;
      PH_NS_Y: next_phase = PH_EW_G;
      PH_EW_G: next_phase = PH_EW_Y;
      PH_EW_Y: next_phase = PH_NS_G;
      default: next_phase = PH_SYNC;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_monitor_lamp_decoder.sv
// Combinational decode of the six lamp bits into a phase code and a legal flag.
module lamp_decoder
  import traffic_pkg::*;
(
  input  logic [LAMP_W-1:0]  lamps_i,
  output logic [PHASE_W-1:0] phase_c_o,
  output logic               legal_c_o
);

  always_comb begin
    phase_c_o = PH_SYNC;
    legal_c_o = 1'b0;
    case (lamps_i)
      LAMP_NS_G: begin phase_c_o = PH_NS_G; legal_c_o = 1'b1; end
      LAMP_NS_Y: begin phase_c_o = PH_NS_Y; legal_c_o = 1'b1; end
      LAMP_EW_G: begin phase_c_o = PH_EW_G; legal_c_o = 1'b1; end
      LAMP_EW_Y: begin phase_c_o = PH_EW_Y; legal_c_o = 1'b1; end
      default:   begin phase_c_o = PH_SYNC; legal_c_o = 1'b0; end
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive monitor for the traffic light lamp interface: tracks phase order and
// dwell time, flags illegal/out-of-order/timing errors and counts clean cycles.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned G_TICKS = G_TICKS_DEFAULT,
  parameter int unsigned Y_TICKS = Y_TICKS_DEFAULT,
  parameter int unsigned CW      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ns_g,
  input  logic               ns_y,
  input  logic               ns_r,
  input  logic               ew_g,
  input  logic               ew_y,
  input  logic               ew_r,
  output logic [PHASE_W-1:0] phase,
  output logic               err_illegal,
  output logic               err_seq,
  output logic               err_timing,
  output logic               err_sticky,
  output logic [CW-1:0]      cycle_count
);

  localparam int unsigned        EXP_W     = DWELL_W + 1;
  localparam logic [DWELL_W-1:0] DWELL_MAX = '1;
  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

  logic [LAMP_W-1:0]  lamps;
  logic [PHASE_W-1:0] dec_phase_raw;
  logic               dec_legal;
  phase_e             dec_phase;

  phase_e             state_q, state_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               chk_en_q, chk_en_d;
  logic               clean_q, clean_d;
  logic               ill_q, ill_d;
  logic               seq_q, seq_d;
  logic               tim_q, tim_d;
  logic               sticky_q, sticky_d;
  logic [CW-1:0]      count_q, count_d;
  logic [EXP_W-1:0]   exp_cur;

  function automatic logic [EXP_W-1:0] exp_ticks(input phase_e p);
    if (p == PH_NS_G || p == PH_EW_G) exp_ticks = EXP_W'(G_TICKS);
    else                              exp_ticks = EXP_W'(Y_TICKS);
  endfunction

  assign lamps = {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r};

  lamp_decoder u_decoder (
    .lamps_i   (lamps),
    .phase_c_o (dec_phase_raw),
    .legal_c_o (dec_legal)
  );

  assign dec_phase = phase_e'(dec_phase_raw);
  assign exp_cur   = exp_ticks(state_q);

  // Phase tracking, dwell checks and cycle accounting.
  always_comb begin
    state_d  = state_q;
    dwell_d  = dwell_q;
    chk_en_d = chk_en_q;
    clean_d  = clean_q;
    count_d  = count_q;
    ill_d    = 1'b0;
    seq_d    = 1'b0;
    tim_d    = 1'b0;

    if (!dec_legal) begin
      state_d  = PH_SYNC;
      dwell_d  = '0;
      chk_en_d = 1'b0;
      ill_d    = 1'b1;
    end else if (state_q == PH_SYNC) begin
      state_d  = dec_phase;
      dwell_d  = DWELL_ONE;
      chk_en_d = 1'b0;
    end else if (dec_phase == state_q) begin
      if (dwell_q != DWELL_MAX) begin
        dwell_d = dwell_q + DWELL_ONE;
        tim_d   = chk_en_q && (EXP_W'(dwell_d) == exp_cur + EXP_W'(1));
      end
    end else if (dec_phase == next_phase(state_q)) begin
      tim_d = chk_en_q && (EXP_W'(dwell_q) < exp_cur);
      if (dec_phase == PH_NS_G && clean_q && !tim_d) count_d = count_q + CW'(1);
      state_d  = dec_phase;
      dwell_d  = DWELL_ONE;
      chk_en_d = 1'b1;
    end else begin
      seq_d    = 1'b1;
      state_d  = dec_phase;
      dwell_d  = DWELL_ONE;
      chk_en_d = 1'b0;
    end

    // A new cycle opens on NS_G entry; errors at that edge belong to the old one.
    if (state_d == PH_NS_G && state_q != PH_NS_G) clean_d = 1'b1;
    else if (ill_d || seq_d || tim_d)              clean_d = 1'b0;

    sticky_d = sticky_q | ill_d | seq_d | tim_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= PH_SYNC;
      dwell_q  <= '0;
      chk_en_q <= 1'b0;
      clean_q  <= 1'b0;
      count_q  <= '0;
      ill_q    <= 1'b0;
      seq_q    <= 1'b0;
      tim_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      chk_en_q <= chk_en_d;
      clean_q  <= clean_d;
      count_q  <= count_d;
      ill_q    <= ill_d;
      seq_q    <= seq_d;
      tim_q    <= tim_d;
      sticky_q <= sticky_d;
    end
  end

  assign phase       = state_q;
  assign err_illegal = ill_q;
  assign err_seq     = seq_q;
  assign err_timing  = tim_q;
  assign err_sticky  = sticky_q;
  assign cycle_count = count_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: scenario tasks plus a scoreboard fed by a
// behavioural reference of the monitor's rules.
`timescale 1ns/1ps
module tb_traffic_light_monitor;

  localparam logic [5:0] P_NSG = 6'b100001;
  localparam logic [5:0] P_NSY = 6'b010001;
  localparam logic [5:0] P_EWG = 6'b001100;
  localparam logic [5:0] P_EWY = 6'b001010;
  localparam logic [5:0] P_BAD = 6'b100100;
  localparam logic [5:0] P_OFF = 6'b000000;
  localparam int G = 5;
  localparam int Y = 2;

  typedef struct packed {
    logic [2:0]  phase;
    logic        ill;
    logic        seq;
    logic        tim;
    logic        sticky;
    logic [15:0] count;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ns_g = 1'b0, ns_y = 1'b0, ns_r = 1'b0, ew_g = 1'b0, ew_y = 1'b0, ew_r = 1'b0;
  logic [2:0]  phase;
  logic        err_illegal, err_seq, err_timing, err_sticky;
  logic [15:0] cycle_count;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t mon_e;

  int          m_ph, m_dw;
  bit          m_chk, m_clean, m_sticky;
  logic [15:0] m_count;

  traffic_light_monitor #(.G_TICKS(G), .Y_TICKS(Y), .CW(16)) dut (
    .clk(clk), .rst(rst),
    .ns_g(ns_g), .ns_y(ns_y), .ns_r(ns_r), .ew_g(ew_g), .ew_y(ew_y), .ew_r(ew_r),
    .phase(phase), .err_illegal(err_illegal), .err_seq(err_seq),
    .err_timing(err_timing), .err_sticky(err_sticky), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  function automatic int decode(input logic [5:0] p);
    case (p)
      P_NSG:   return 1;
      P_NSY:   return 2;
      P_EWG:   return 3;
      P_EWY:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int texp(input int ph);
    return (ph == 1 || ph == 3) ? G : Y;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_dw = 0; m_chk = 0; m_clean = 0; m_sticky = 0; m_count = '0;
    sb.delete();
  endtask

  // Reference rules applied to one sampled lamp pattern.
  task automatic model_push(input logic [5:0] p);
    int np, prev;
    exp_t e;
    np = decode(p);
    prev = m_ph;
    e = '0;
    if (np == 0) begin
      e.ill = 1; m_ph = 0; m_dw = 0; m_chk = 0;
    end else if (m_ph == 0) begin
      m_ph = np; m_dw = 1; m_chk = 0;
    end else if (np == m_ph) begin
      if (m_dw < 255) begin
        m_dw = m_dw + 1;
        if (m_chk && m_dw == texp(m_ph) + 1) e.tim = 1;
      end
    end else if (np == (m_ph % 4) + 1) begin
      if (m_chk && m_dw < texp(m_ph)) e.tim = 1;
      if (np == 1 && m_clean && !e.tim) m_count = m_count + 16'd1;
      m_ph = np; m_dw = 1; m_chk = 1;
    end else begin
      e.seq = 1; m_ph = np; m_dw = 1; m_chk = 0;
    end
    if (np == 1 && prev != 1) m_clean = 1;
    else if (e.ill || e.seq || e.tim) m_clean = 0;
    m_sticky = m_sticky | e.ill | e.seq | e.tim;
    e.phase = 3'(m_ph);
    e.sticky = m_sticky;
    e.count = m_count;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [5:0] p);
    {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} = p;
    model_push(p);
    @(posedge clk); #2;
  endtask

  task automatic drive_n(input logic [5:0] p, input int n);
    for (int i = 0; i < n; i++) drive(p);
  endtask

  // Scoreboard: each sampled pattern's expected outputs, checked 1 ns after the edge.
  always @(posedge clk) begin
    #1;
    if (!rst && sb.size() > 0) begin
      mon_e = sb.pop_front();
      total++; if (phase !== mon_e.phase) begin bad++; $display("FAIL sb_phase: got %0d want %0d at %0t", phase, mon_e.phase, $time); end
      total++; if (err_illegal !== mon_e.ill) begin bad++; $display("FAIL sb_illegal: got %b want %b at %0t", err_illegal, mon_e.ill, $time); end
      total++; if (err_seq !== mon_e.seq) begin bad++; $display("FAIL sb_seq: got %b want %b at %0t", err_seq, mon_e.seq, $time); end
      total++; if (err_timing !== mon_e.tim) begin bad++; $display("FAIL sb_timing: got %b want %b at %0t", err_timing, mon_e.tim, $time); end
      total++; if (err_sticky !== mon_e.sticky) begin bad++; $display("FAIL sb_sticky: got %b want %b at %0t", err_sticky, mon_e.sticky, $time); end
      total++; if (cycle_count !== mon_e.count) begin bad++; $display("FAIL sb_count: got %0d want %0d at %0t", cycle_count, mon_e.count, $time); end
    end
  end

  task automatic test_reset();
    model_reset();
    #11;
    total++; if (phase !== 3'd0) begin bad++; $display("FAIL por_phase: got %0d want 0", phase); end
    total++; if ({err_illegal, err_seq, err_timing, err_sticky} !== 4'b0) begin bad++; $display("FAIL por_err: got %b want 0000", {err_illegal, err_seq, err_timing, err_sticky}); end
    total++; if (cycle_count !== 16'd0) begin bad++; $display("FAIL por_count: got %0d want 0", cycle_count); end
    #1 rst = 1'b0;
    drive(P_OFF);
    drive_n(P_NSG, 3);
    total++; if (phase !== 3'd1 || err_sticky !== 1'b1) begin bad++; $display("FAIL pre_rst: got phase=%0d sticky=%b want 1/1", phase, err_sticky); end
    rst = 1'b1;
    model_reset();
    #1;
    total++; if (phase !== 3'd0) begin bad++; $display("FAIL rst_phase: got %0d want 0", phase); end
    total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL rst_sticky: got %b want 0", err_sticky); end
    total++; if ({err_illegal, err_seq, err_timing} !== 3'b0) begin bad++; $display("FAIL rst_err: got %b want 000", {err_illegal, err_seq, err_timing}); end
    total++; if (cycle_count !== 16'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", cycle_count); end
    #11 rst = 1'b0;
  endtask

  task automatic test_clean_cycle();
    logic [5:0] pats [4];
    int dur [4];
    pats = '{P_NSG, P_NSY, P_EWG, P_EWY};
    dur = '{G, Y, G, Y};
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < 4; k++)
        for (int n = 0; n < dur[k]; n++) begin
          drive(pats[k]);
          if (n == 0) begin
            total++; if (phase !== 3'(k + 1)) begin bad++; $display("FAIL clean_phase: got %0d want %0d", phase, k + 1); end
          end
          if (c == 1 && k == 0 && n == 0) begin
            total++; if (cycle_count !== 16'd1) begin bad++; $display("FAIL clean_count1: got %0d want 1", cycle_count); end
          end
        end
    drive(P_NSG);
    total++; if (cycle_count !== 16'd2) begin bad++; $display("FAIL clean_count2: got %0d want 2", cycle_count); end
    total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL clean_sticky: got %b want 0", err_sticky); end
  endtask

  task automatic test_short_yellow();
    drive_n(P_NSG, 4);
    drive(P_NSY);
    drive(P_EWG);
    total++; if (err_timing !== 1'b1 || err_sticky !== 1'b1) begin bad++; $display("FAIL short_y: got tim=%b sticky=%b want 1/1", err_timing, err_sticky); end
    drive_n(P_EWG, 4);
    total++; if (err_timing !== 1'b0) begin bad++; $display("FAIL short_y_clear: got %b want 0", err_timing); end
    drive_n(P_EWY, 2);
    drive(P_NSG);
    total++; if (cycle_count !== 16'd2 || phase !== 3'd1) begin bad++; $display("FAIL short_y_count: got count=%0d phase=%0d want 2/1", cycle_count, phase); end
  endtask

  task automatic test_long_green();
    int pulses = 0;
    int at = 0;
    for (int i = 2; i <= 260; i++) begin
      drive(P_NSG);
      if (err_timing === 1'b1) begin pulses++; at = i; end
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL long_g_pulses: got %0d want 1", pulses); end
    total++; if (at != 6) begin bad++; $display("FAIL long_g_at: got sample %0d want 6", at); end
  endtask

  task automatic test_skip();
    int pulses = 0;
    drive(P_EWG);
    total++; if (err_seq !== 1'b1 || err_timing !== 1'b0 || phase !== 3'd3) begin bad++; $display("FAIL skip: got seq=%b tim=%b phase=%0d want 1/0/3", err_seq, err_timing, phase); end
    for (int i = 0; i < 8; i++) begin
      drive(P_EWG);
      if (err_timing === 1'b1) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL skip_timing: got %0d pulses want 0", pulses); end
  endtask

  task automatic test_illegal();
    drive(P_BAD);
    total++; if (err_illegal !== 1'b1 || err_seq !== 1'b0 || phase !== 3'd0) begin bad++; $display("FAIL illegal: got ill=%b seq=%b phase=%0d want 1/0/0", err_illegal, err_seq, phase); end
    drive(P_OFF);
    total++; if (err_illegal !== 1'b1 || phase !== 3'd0) begin bad++; $display("FAIL all_off: got ill=%b phase=%0d want 1/0", err_illegal, phase); end
    drive(P_EWY);
    total++; if (phase !== 3'd4 || {err_illegal, err_seq, err_timing} !== 3'b0) begin bad++; $display("FAIL resync: got phase=%0d errs=%b want 4/000", phase, {err_illegal, err_seq, err_timing}); end
    drive(P_NSG);
    total++; if (cycle_count !== 16'd2 || err_timing !== 1'b0) begin bad++; $display("FAIL resync_count: got count=%0d tim=%b want 2/0", cycle_count, err_timing); end
  endtask

  task automatic test_closed_loop();
    logic [5:0] pats [4];
    int dur [4];
    int ph = 0;
    int t = 0;
    pats = '{P_NSG, P_NSY, P_EWG, P_EWY};
    dur = '{G, Y, G, Y};
    rst = 1'b1;
    model_reset();
    #12 rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      drive(pats[ph]);
      t++;
      if (t == dur[ph]) begin t = 0; ph = (ph + 1) % 4; end
    end
    total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL loop_sticky: got %b want 0", err_sticky); end
    total++; if (cycle_count < 16'd1) begin bad++; $display("FAIL loop_count: got %0d want >=1", cycle_count); end
  endtask

  initial begin
    test_reset();
    test_clean_cycle();
    test_short_yellow();
    test_long_green();
    test_skip();
    test_illegal();
    test_closed_loop();
    @(posedge clk); #2;
    total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_drain: got %0d pending want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
